// File: rtl/bitwise_tt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_tt_pkg
//  Description : Shared types and constants for the bitwise truth-table
//                sequencer: FSM state encoding, golden truth table, counter
//                widths and a per-combination golden byte lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package bitwise_tt_pkg;

    // Width of the operand-combination index {a,b}
    localparam int COMBO_W = 2;
    // Width of the settle/hold counter (covers HOLD_CYCLES up to 15)
    localparam int HOLD_W  = 4;

    // Expected truth table {r3,r2,r1,r0}; byte k is the operator result
    // for operand combination k = {a,b}.
    localparam logic [31:0] TT_GOLDEN = 32'h8BA63678;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Golden result byte for operand combination k.
    function automatic logic [7:0] golden_byte(input logic [COMBO_W-1:0] k);
        return TT_GOLDEN[{k, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitwise_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_hold_timer
//  Description : Settle-time counter. Clears to zero on i_clr, counts up
//                while i_en is high, and flags o_expire when the count
//                equals HOLD_CYCLES-1.
//  Ports       : clk, rst    - clock and synchronous active-high reset
//                i_clr       - synchronous clear (priority over enable)
//                i_en        - count enable
//                o_expire    - count has reached HOLD_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_hold_timer
    import bitwise_tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [HOLD_W-1:0] C_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/bitwise_tt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_tt_sequencer
//  Description : Drives all four {a,b} operand combinations into a 2-input
//                bitwise operator block, waits HOLD_CYCLES per combination,
//                captures the eight operator results into a 32-bit truth
//                table and compares it against TT_GOLDEN.
//  Parameters  : HOLD_CYCLES  - drive cycles per combination (1..15)
//  Ports       : clk_in, rst_in  - clock, synchronous active-high reset
//                start_in        - run request (honoured only in IDLE)
//                res_in[7:0]     - operator results {y7..y0}
//                a_out, b_out    - registered operands to the operator
//                busy_out        - run in progress (DRIVE/SAMPLE)
//                done_out        - one-cycle completion pulse
//                pass_out        - last run matched golden table
//                err_cnt_out[2:0]- mismatching combinations in last run
//                tt_out[31:0]    - captured table {r3,r2,r1,r0}
//                fail_mask_out[3:0] - per-combination mismatch flags
//                                  (present only with TT_FAIL_MASK_EN)
//  Options     : `define TT_FAIL_MASK_EN to add fail_mask_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module bitwise_tt_sequencer
    import bitwise_tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [7:0]  res_in,
    output logic        a_out,
    output logic        b_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        pass_out,
    output logic [2:0]  err_cnt_out,
    output logic [31:0] tt_out
`ifdef TT_FAIL_MASK_EN
    ,
    output logic [3:0]  fail_mask_out
`endif
);

    localparam logic [COMBO_W-1:0] C_LAST_COMBO = '1;

    state_t             r_state;
    logic [COMBO_W-1:0] r_k;
    logic               r_a;
    logic               r_b;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [2:0]         r_err_cnt;
    logic [31:0]        r_tt;
    logic [3:0]         r_fail_mask;

    logic               w_expire;
    logic               w_mismatch;
    logic [2:0]         w_err_next;
    logic [COMBO_W-1:0] w_k_next;

    // The hold counter only runs in DRIVE; any other state holds it at 0 so
    // each new combination starts a fresh settle window.
    bitwise_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk      (clk_in),
        .rst      (rst_in),
        .i_clr    (r_state != DRIVE),
        .i_en     (r_state == DRIVE),
        .o_expire (w_expire)
    );

    assign w_mismatch = (res_in != golden_byte(r_k));
    // At most four increments per run, so the 3-bit count never wraps.
    assign w_err_next = r_err_cnt + {2'b00, w_mismatch};
    assign w_k_next   = r_k + 1'b1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_k         <= '0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_tt        <= '0;
            r_fail_mask <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_in) begin
                        r_state     <= DRIVE;
                        r_k         <= '0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_tt        <= '0;
                        r_fail_mask <= '0;
                    end
                end

                DRIVE: begin
                    if (w_expire) begin
                        r_state <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    r_tt[{r_k, 3'b000} +: 8] <= res_in;
                    r_err_cnt                <= w_err_next;
                    r_fail_mask[r_k]         <= w_mismatch;
                    if (r_k == C_LAST_COMBO) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        // Uses the count including this final compare so the
                        // verdict is valid in the same cycle as done_out.
                        r_pass  <= (w_err_next == 3'd0);
                    end else begin
                        r_state      <= DRIVE;
                        r_k          <= w_k_next;
                        {r_a, r_b}   <= w_k_next;
                    end
                end

                DONE: begin
                    // start_in is deliberately ignored here; only IDLE
                    // accepts a new run.
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign a_out       = r_a;
    assign b_out       = r_b;
    assign busy_out    = r_busy;
    assign done_out    = r_done;
    assign pass_out    = r_pass;
    assign err_cnt_out = r_err_cnt;
    assign tt_out      = r_tt;

`ifdef TT_FAIL_MASK_EN
    assign fail_mask_out = r_fail_mask;
`else
    // Mask is still tracked internally but has no consumer in this build.
    logic w_unused_mask;
    assign w_unused_mask = ^r_fail_mask;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitwise_tt_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitwise_tt_sequencer
//  Description : Bench for bitwise_tt_sequencer. Two instances: HOLD_CYCLES=1
//                with a combinational operator, and HOLD_CYCLES=4 with the
//                operator outputs delayed by three register stages. A fault
//                overlay (stuck-at-1 / stuck-at-0 masks) is applied to the
//                operator results and the expected table is computed from
//                the operator's boolean functions and the golden constant.
//  Options     : `define TT_FAIL_MASK_EN to also check fail_mask_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitwise_tt_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Run-level controls
    logic       sel       = 1'b0;   // 0: HOLD=1 instance, 1: HOLD=4 instance
    logic       start_req = 1'b0;
    logic [7:0] f_or      = 8'h00;  // stuck-at-1 bits
    logic [7:0] f_clr     = 8'h00;  // stuck-at-0 bits

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference operator: y0=AND y1=OR y2=XOR y3=XNOR y4=NOT a y5=NAND
    // y6=NOR y7=a
    function automatic logic [7:0] op_f(input logic a, input logic b);
        return {a, ~(a | b), ~(a & b), ~a, ~(a ^ b), a ^ b, a | b, a & b};
    endfunction

    function automatic logic [7:0] fault_f(input logic [7:0] v);
        return (v | f_or) & ~f_clr;
    endfunction

    // ---------------- HOLD_CYCLES = 1 instance -------------------------
    logic        a1, b1, busy1, done1, pass1;
    logic [2:0]  err1;
    logic [31:0] tt1;
    logic [7:0]  res1;
    logic        start1;
    assign start1 = start_req & ~sel;
    assign res1   = fault_f(op_f(a1, b1));

    // ---------------- HOLD_CYCLES = 4 instance -------------------------
    logic        a4, b4, busy4, done4, pass4;
    logic [2:0]  err4;
    logic [31:0] tt4;
    logic [7:0]  res4;
    logic [7:0]  d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
    logic        start4;
    assign start4 = start_req & sel;
    always @(posedge clk) begin
        d1 <= op_f(a4, b4);
        d2 <= d1;
        d3 <= d2;
    end
    assign res4 = fault_f(d3);

`ifdef TT_FAIL_MASK_EN
    logic [3:0] fm1, fm4, m_fm;
    assign m_fm = sel ? fm4 : fm1;
`endif

    bitwise_tt_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start1),
        .res_in      (res1),
        .a_out       (a1),
        .b_out       (b1),
        .busy_out    (busy1),
        .done_out    (done1),
        .pass_out    (pass1),
        .err_cnt_out (err1),
        .tt_out      (tt1)
`ifdef TT_FAIL_MASK_EN
        ,
        .fail_mask_out (fm1)
`endif
    );

    bitwise_tt_sequencer #(.HOLD_CYCLES(4)) dut4 (
        .clk_in      (clk),
        .rst_in      (rst),
        .start_in    (start4),
        .res_in      (res4),
        .a_out       (a4),
        .b_out       (b4),
        .busy_out    (busy4),
        .done_out    (done4),
        .pass_out    (pass4),
        .err_cnt_out (err4),
        .tt_out      (tt4)
`ifdef TT_FAIL_MASK_EN
        ,
        .fail_mask_out (fm4)
`endif
    );

    // Observation mux for the selected instance
    logic        m_a, m_b, m_busy, m_done, m_pass;
    logic [2:0]  m_err;
    logic [31:0] m_tt;
    assign m_a    = sel ? a4    : a1;
    assign m_b    = sel ? b4    : b1;
    assign m_busy = sel ? busy4 : busy1;
    assign m_done = sel ? done4 : done1;
    assign m_pass = sel ? pass4 : pass1;
    assign m_err  = sel ? err4  : err1;
    assign m_tt   = sel ? tt4   : tt1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a1b1"}, {30'd0, a1, b1}, 32'd0);
        chk({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_done1"}, {31'd0, done1}, 32'd0);
        chk({tag, "_pass1"}, {31'd0, pass1}, 32'd0);
        chk({tag, "_err1"}, {29'd0, err1}, 32'd0);
        chk({tag, "_tt1"}, tt1, 32'd0);
        chk({tag, "_tt4"}, tt4, 32'd0);
        chk({tag, "_busy4"}, {31'd0, busy4}, 32'd0);
`ifdef TT_FAIL_MASK_EN
        chk({tag, "_fm1"}, {28'd0, fm1}, 32'd0);
`endif
    endtask

    // One run on the selected instance. Called at a negedge; raises start so
    // it is accepted at the following posedge (E0). Iteration i observes the
    // cycle that begins at edge E0+i. Extra start pulses are raised during
    // iterations inj1/inj2 to check they are ignored.
    task automatic run(input logic s, input int inj1, input int inj2);
        int          h;
        int          per;
        int          ndone;
        logic [31:0] gold;
        logic [31:0] exp_tt;
        logic [2:0]  exp_err;
        logic [3:0]  exp_mask;
        logic [7:0]  byte_v;
        sel   = s;
        h     = s ? 4 : 1;
        per   = h + 1;
        ndone = 0;
        gold  = 32'h8BA63678;
        exp_tt   = '0;
        exp_err  = '0;
        exp_mask = '0;
        for (int k = 0; k < 4; k++) begin
            byte_v = fault_f(op_f(k[1], k[0]));
            exp_tt[8*k +: 8] = byte_v;
            if (byte_v != gold[8*k +: 8]) begin
                exp_err     = exp_err + 3'd1;
                exp_mask[k] = 1'b1;
            end
        end
        start_req = 1'b1;
        for (int i = 0; i <= 4 * per + 1; i++) begin
            @(negedge clk);
            start_req = (i == inj1) || (i == inj2);
            chk("operands", {30'd0, m_a, m_b}, (i < 4 * per) ? 32'(i / per) : 32'd0);
            chk("busy", {31'd0, m_busy}, (i < 4 * per) ? 32'd1 : 32'd0);
            chk("done", {31'd0, m_done}, (i == 4 * per) ? 32'd1 : 32'd0);
            if (m_done) ndone++;
            if (i < per) begin
                chk("tt_cleared", m_tt, 32'd0);
                chk("err_cleared", {29'd0, m_err}, 32'd0);
                chk("pass_cleared", {31'd0, m_pass}, 32'd0);
            end
            if (i >= 4 * per) begin
                chk("tt", m_tt, exp_tt);
                chk("err_cnt", {29'd0, m_err}, {29'd0, exp_err});
                chk("pass", {31'd0, m_pass}, (exp_err == 3'd0) ? 32'd1 : 32'd0);
`ifdef TT_FAIL_MASK_EN
                chk("fail_mask", {28'd0, m_fm}, {28'd0, exp_mask});
`endif
            end
        end
        chk("done_pulses", ndone, 1);
        start_req = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean run, HOLD=1
        run(1'b0, -1, -1);
        chk("clean_tt_const", tt1, 32'h8BA63678);
        repeat (2) @(negedge clk);

        // res_in[0] stuck at 1
        f_or = 8'h01;
        run(1'b0, -1, -1);
        chk("stuck_tt_const", tt1, 32'h8BA73779);
        chk("stuck_err_const", {29'd0, err1}, 32'd3);
        f_or = 8'h00;
        repeat (2) @(negedge clk);

        // Start pulses during DRIVE of k=1 and during DONE
        run(1'b0, 2, 8);
        repeat (2) @(negedge clk);

        // Reset during DRIVE of k=2
        sel       = 1'b0;
        start_req = 1'b1;
        @(negedge clk);
        start_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_busy", {31'd0, busy1}, 32'd1);
        chk("midrun_ab", {30'd0, a1, b1}, 32'd2);
        chk("midrun_tt", tt1, 32'h00003678);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midrun_reset");
        rst = 1'b0;
        @(negedge clk);
        run(1'b0, -1, -1);
        repeat (2) @(negedge clk);

        // Long hold with delayed operator
        run(1'b1, -1, -1);
        repeat (2) @(negedge clk);

        // Back-to-back: faulty run, then clean run started right after DONE
        f_clr = 8'h80;
        run(1'b0, -1, -1);
        f_clr = 8'h00;
        run(1'b0, -1, -1);

        // Randomized fault overlays on both instances
        for (int r = 0; r < 10; r++) begin
            f_or  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            f_clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
            run(1'($urandom_range(0, 1)), -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        f_or  = 8'h00;
        f_clr = 8'h00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
